ewb_drain: RTL and testbench
============================

Name: ewb_drain

Overview:
Eviction write buffer between the L1 cache datapath and physical memory.
- Accepts dirty 256-bit lines evicted from the cache data array and queues them.
- Drains them to memory via pmem_write when memory is free.
- Passes cache line-fill reads through to memory, with reads taking priority over draining.
- Guarantees a read never returns stale data for an address still held in the buffer.

Parameters:
- width, 256, line width in bits
- addr_width, 32, byte address width
- depth, 4, number of buffer entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ewb_push  in  1  push evicted line, single-cycle qualifier
- ewb_addr  in  addr_width  evicted line address
- ewb_wdata  in  width  evicted line data
- ewb_ready  out  1  buffer can accept a push this cycle
- c_read  in  1  cache line-fill request, held until c_resp
- c_address  in  addr_width  fill address
- c_rdata  out  width  fill data, valid with c_resp
- c_resp  out  1  one-cycle fill completion pulse
- pmem_read  out  1  memory read request
- pmem_write  out  1  memory write request
- pmem_address  out  addr_width  memory address
- pmem_wdata  out  width  memory write data
- pmem_rdata  in  width  memory read data
- pmem_resp  in  1  memory completion pulse

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - All entries invalid; head = tail = 0; state IDLE.
  - ewb_ready = 1.
  - c_resp, pmem_read, pmem_write = 0.
  - pmem_address, pmem_wdata, c_rdata = 0.
- Reset mid-transaction drops all queued lines and the in-flight request. The memory model must tolerate an abandoned request.
- Line compare uses addr[addr_width-1:5]; offset bits are ignored.
- Storage is a circular FIFO of {valid, addr, data}. count ranges 0..depth.
- ewb_ready = (count != depth). It is registered-count based, so a pop in the same cycle does not make room.
- Push accepted when ewb_push && ewb_ready. Entry written at clock edge.
  - Coalesce: if pushed address matches a valid non-head entry, or the head while in IDLE, overwrite that entry's data. count unchanged.
  - If it matches the head while in WRITE, append as a new entry. In-flight pmem_wdata must stay stable.
- FSM states: IDLE, READ, WRITE, FWD.
- IDLE transitions, in priority order:
  - c_read with buffer hit:
    - With the optional feature compiled in: -> FWD.
    - Without it: -> WRITE, so the buffer drains until the conflict clears.
  - c_read, no hit -> READ.
  - count != 0 -> WRITE.
- READ:
  - pmem_read = 1, pmem_address = c_address.
  - On pmem_resp: c_resp = 1 that cycle, c_rdata = pmem_rdata (combinational pass), -> IDLE.
- WRITE:
  - pmem_write = 1, address and data taken from the head entry.
  - On pmem_resp: invalidate head, head++ (wraps modulo depth), count--, -> IDLE. Drains are never preempted mid-transaction.
- FWD:
  - c_resp = 1, c_rdata = data of the matching entry, registered on entry to FWD. -> IDLE.
  - Entry is not removed.
- Latency from IDLE:
  - Miss read: c_resp in the same cycle as pmem_resp.
  - Forwarded hit: c_resp 1 cycle after c_read is sampled.
  - First drain: pmem_write asserted 1 cycle after push, if no c_read is pending.
- Simultaneous push and pop: both take effect; count unchanged.
- Multiple matches cannot occur, because coalescing prevents duplicates. The one exception is the head-in-WRITE case, where the newest (tail-side) match wins.

Optional Feature:
EWB_FWD_EN
- Defined: a read hitting a buffered line is served from the buffer via FWD, with no memory access.
- Undefined: FWD state is absent. A hitting read forces drains until no valid entry matches, then proceeds through READ.

Decomposition:
- Package ewb_pkg:
  - line_t (logic [width-1:0]) and addr_t.
  - LINE_OFFSET_BITS = 5.
  - state_t enum {IDLE, READ, WRITE, FWD}.
- Sub-module ewb_entry_store:
  - Holds the FIFO storage, head/tail/count, and the parallel address compare.
  - Outputs per-port hit and hit index.
- ewb_drain keeps the FSM and the muxing onto pmem/cache ports.

Test Plan:
- Push line A (0x1000, data 0xAA..) with memory idle -> pmem_write next cycle, addr 0x1000, data 0xAA..; after pmem_resp, count = 0 and ewb_ready = 1.
- Push 4 distinct lines while memory stalls resp -> ewb_ready = 0 after the 4th; a 5th push is ignored; drains occur in FIFO order 1, 2, 3, 4.
- Push 0x2000 data X, then 0x2000 data Y while not draining -> exactly one pmem_write, carrying data Y.
- Buffer holds 0x3000 data Z, c_read 0x3000 -> with EWB_FWD_EN: c_resp after 1 cycle, c_rdata = Z, no pmem_read. Without it: pmem_write of Z completes before pmem_read 0x3000.
- Buffer non-empty, c_read to a miss address in IDLE -> pmem_read is issued before the next pmem_write; c_rdata = pmem_rdata.
- Assert rst_n = 0 during WRITE with 3 entries queued -> pmem_write drops immediately; after release, count = 0, ewb_ready = 1, no further memory traffic.

Source files
------------

// File: rtl/ewb_pkg.sv
// Shared types and constants for the eviction write buffer.
//   line_t / addr_t : default line and address types (256-bit line, 32-bit byte address)
//   state_t         : drain FSM states
//   LINE_OFFSET_BITS: byte-offset bits ignored by every line compare
package ewb_pkg;

    localparam int unsigned LINE_WIDTH       = 256;
    localparam int unsigned ADDR_WIDTH       = 32;
    localparam int unsigned LINE_OFFSET_BITS = 5;

    typedef logic [LINE_WIDTH-1:0] line_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FWD   = 2'd3
    } state_t;

endpackage

// File: rtl/ewb_entry_store.sv
// Circular FIFO of {valid, addr, data} for evicted lines, with parallel line compare.
//   clk_i, rst_ni     : clock, async active-low reset
//   push_i            : accepted push (already qualified by ready_o)
//   push_addr_i/data_i: pushed line; coalesces into a matching entry, else appends at tail
//   head_busy_i       : head is in flight to memory, so it must not be overwritten
//   pop_i             : retire the head entry
//   rd_line_i         : line address of the pending fill, compared against all valid entries
//   ready_o, empty_o  : count != depth, count == 0 (registered count)
//   head_addr_o/data_o: head entry contents
//   rd_hit_o          : fill address matches a valid entry
//   rd_hit_data_o     : data of the newest matching entry (only with EWB_FWD_EN)
module ewb_entry_store
    import ewb_pkg::*;
#(
    parameter int unsigned width      = LINE_WIDTH,
    parameter int unsigned addr_width = ADDR_WIDTH,
    parameter int unsigned depth      = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  push_i,
    input  logic [addr_width-1:0]                 push_addr_i,
    input  logic [width-1:0]                      push_data_i,
    input  logic                                  head_busy_i,
    input  logic                                  pop_i,
    input  logic [addr_width-1:LINE_OFFSET_BITS]  rd_line_i,
    output logic                                  ready_o,
    output logic                                  empty_o,
    output logic [addr_width-1:0]                 head_addr_o,
    output logic [width-1:0]                      head_data_o,
    output logic                                  rd_hit_o
`ifdef EWB_FWD_EN
    ,
    output logic [width-1:0]                      rd_hit_data_o
`endif
);

    localparam int unsigned IdxW = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned CntW = $clog2(depth + 1);

    typedef logic [IdxW-1:0] idx_t;

    logic [depth-1:0]      valid_q, valid_d;
    logic [addr_width-1:0] addr_q [depth];
    logic [width-1:0]      data_q [depth];
    idx_t                  head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;

    logic rd_hit, push_hit, append;
    idx_t push_idx, wr_idx, idx;
`ifdef EWB_FWD_EN
    idx_t rd_idx;
`endif

    // Walk from oldest to newest so a later (tail-side) match overrides an earlier one.
    always_comb begin
        rd_hit   = 1'b0;
        push_hit = 1'b0;
        push_idx = '0;
        idx      = '0;
`ifdef EWB_FWD_EN
        rd_idx   = '0;
`endif
        for (int unsigned i = 0; i < depth; i++) begin
            idx = head_q + idx_t'(i);
            if (valid_q[idx] && addr_q[idx][addr_width-1:LINE_OFFSET_BITS] == rd_line_i) begin
                rd_hit = 1'b1;
`ifdef EWB_FWD_EN
                rd_idx = idx;
`endif
            end
            if (valid_q[idx] && !(head_busy_i && i == 0) &&
                addr_q[idx][addr_width-1:LINE_OFFSET_BITS] ==
                push_addr_i[addr_width-1:LINE_OFFSET_BITS]) begin
                push_hit = 1'b1;
                push_idx = idx;
            end
        end
    end

    assign append = push_i && !push_hit;
    assign wr_idx = push_hit ? push_idx : tail_q;

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop_i) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + idx_t'(1);
        end
        if (append) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + idx_t'(1);
        end
        count_d = count_q + CntW'(append) - CntW'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: nothing reads it while its valid bit is clear.
    // A coalesce keeps the original address and replaces only the data.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            data_q[wr_idx] <= push_data_i;
            if (!push_hit) begin
                addr_q[tail_q] <= push_addr_i;
            end
        end
    end

    assign ready_o     = (count_q != CntW'(depth));
    assign empty_o     = (count_q == '0);
    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign rd_hit_o    = rd_hit;
`ifdef EWB_FWD_EN
    assign rd_hit_data_o = data_q[rd_idx];
`endif

endmodule

// File: rtl/ewb_drain.sv
// Eviction write buffer between the L1 datapath and physical memory.
// Queues dirty evicted lines, drains them with pmem_write when memory is free, and passes
// line-fill reads through with priority over draining. A fill never sees stale memory data
// for a line still held in the buffer.
// Optional feature macro EWB_FWD_EN: a fill hitting the buffer is answered from the buffer
// (FWD state). Without it, a hitting fill forces drains until no entry matches, then reads.
//   clk, rst_n                       : clock, async active-low reset
//   ewb_push/addr/wdata, ewb_ready   : eviction push side
//   c_read/c_address, c_rdata/c_resp : cache fill side
//   pmem_read/write/address/wdata    : memory request side
//   pmem_rdata/pmem_resp             : memory response side
module ewb_drain
    import ewb_pkg::*;
#(
    parameter int unsigned width      = LINE_WIDTH,
    parameter int unsigned addr_width = ADDR_WIDTH,
    parameter int unsigned depth      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ewb_push,
    input  logic [addr_width-1:0] ewb_addr,
    input  logic [width-1:0]      ewb_wdata,
    output logic                  ewb_ready,
    input  logic                  c_read,
    input  logic [addr_width-1:0] c_address,
    output logic [width-1:0]      c_rdata,
    output logic                  c_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [addr_width-1:0] pmem_address,
    output logic [width-1:0]      pmem_wdata,
    input  logic [width-1:0]      pmem_rdata,
    input  logic                  pmem_resp
);

    state_t state_q, state_d;

    logic                  push_acc, push_rd_hit, st_rd_hit, rd_hit;
    logic                  empty, pop;
    logic [addr_width-1:0] head_addr;
    logic [width-1:0]      head_data;
`ifdef EWB_FWD_EN
    logic [width-1:0]      st_hit_data;
    logic [width-1:0]      fwd_q, fwd_d;
`endif

    assign push_acc = ewb_push && ewb_ready;

    // A push landing in the same cycle as a fill to the same line is not in the store yet,
    // but its data is newer than memory, so it counts as a hit.
    assign push_rd_hit = push_acc && (ewb_addr[addr_width-1:LINE_OFFSET_BITS] ==
                                      c_address[addr_width-1:LINE_OFFSET_BITS]);
    assign rd_hit = st_rd_hit || push_rd_hit;

    ewb_entry_store #(
        .width      (width),
        .addr_width (addr_width),
        .depth      (depth)
    ) u_store (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .push_i        (push_acc),
        .push_addr_i   (ewb_addr),
        .push_data_i   (ewb_wdata),
        .head_busy_i   (state_q == WRITE),
        .pop_i         (pop),
        .rd_line_i     (c_address[addr_width-1:LINE_OFFSET_BITS]),
        .ready_o       (ewb_ready),
        .empty_o       (empty),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .rd_hit_o      (st_rd_hit)
`ifdef EWB_FWD_EN
        ,
        .rd_hit_data_o (st_hit_data)
`endif
    );

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        c_resp       = 1'b0;
        c_rdata      = '0;
`ifdef EWB_FWD_EN
        fwd_d        = fwd_q;
`endif
        case (state_q)
            IDLE: begin
                if (c_read && rd_hit) begin
`ifdef EWB_FWD_EN
                    state_d = FWD;
                    fwd_d   = push_rd_hit ? ewb_wdata : st_hit_data;
`else
                    state_d = WRITE;
`endif
                end else if (c_read) begin
                    state_d = READ;
                end else if (!empty || push_acc) begin
                    // Including the incoming push starts the first drain the cycle after it.
                    state_d = WRITE;
                end
            end
            READ: begin
                pmem_read    = 1'b1;
                pmem_address = c_address;
                if (pmem_resp) begin
                    c_resp  = 1'b1;
                    c_rdata = pmem_rdata;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                pmem_write   = 1'b1;
                pmem_address = head_addr;
                pmem_wdata   = head_data;
                if (pmem_resp) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef EWB_FWD_EN
            FWD: begin
                c_resp  = 1'b1;
                c_rdata = fwd_q;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef EWB_FWD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q <= '0;
        end else begin
            fwd_q <= fwd_d;
        end
    end
`endif

endmodule

// File: tb/tb_ewb_drain.sv
// Scoreboard bench for ewb_drain: directed stimulus pushes expected memory/cache events
// into a queue; a monitor pops and compares on every pmem_resp and c_resp.
module tb_ewb_drain;
    import ewb_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  ewb_push, ewb_ready, c_read, c_resp;
    addr_t ewb_addr, c_address, pmem_address;
    line_t ewb_wdata, c_rdata, pmem_wdata, pmem_rdata;
    logic  pmem_read, pmem_write, pmem_resp;

    always #5 clk = ~clk;

    ewb_drain u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ewb_push     (ewb_push),
        .ewb_addr     (ewb_addr),
        .ewb_wdata    (ewb_wdata),
        .ewb_ready    (ewb_ready),
        .c_read       (c_read),
        .c_address    (c_address),
        .c_rdata      (c_rdata),
        .c_resp       (c_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    typedef enum int {EvWr, EvRd, EvResp} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        addr_t    addr;
        line_t    data;
    } ev_t;

    ev_t   exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  mem_stall;
    int    mem_wait;
    line_t mem_store [addr_t];

    function automatic addr_t line_of(addr_t a);
        return {a[31:5], 5'b0};
    endfunction

    function automatic line_t pat(addr_t a);
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    // Memory model: answers after at least one wait cycle unless stalled; tolerates a request
    // abandoned by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            mem_wait   <= 0;
        end else begin
            pmem_resp <= 1'b0;
            if ((pmem_read || pmem_write) && !pmem_resp) begin
                if (!mem_stall && mem_wait >= 1) begin
                    pmem_resp <= 1'b1;
                    mem_wait  <= 0;
                    if (pmem_write) begin
                        mem_store[line_of(pmem_address)] = pmem_wdata;
                    end else begin
                        pmem_rdata <= mem_store.exists(line_of(pmem_address)) ?
                                      mem_store[line_of(pmem_address)] : pat(pmem_address);
                    end
                end else begin
                    mem_wait <= mem_wait + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_e k, input addr_t a, input line_t d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input ev_kind_e k, input addr_t a, input line_t d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got event kind %0d addr %h, expected no event", k, a);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", 256'(k), 256'(e.kind));
            if (k == EvWr || k == EvRd) chk("sb_addr", 256'(a), 256'(e.addr));
            if (k != EvRd) chk("sb_data", d, e.data);
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pmem_resp && pmem_write) sb_check(EvWr, pmem_address, pmem_wdata);
                if (pmem_resp && pmem_read) sb_check(EvRd, pmem_address, '0);
                if (c_resp) sb_check(EvResp, '0, c_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input addr_t a, input line_t d);
        ewb_push  = 1'b1;
        ewb_addr  = a;
        ewb_wdata = d;
        tick();
        ewb_push  = 1'b0;
    endtask

    // Waits for c_resp, checks whether it coincides with pmem_resp, returns at posedge+1.
    task automatic wait_cresp(input string name, input logic exp_presp);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (c_resp) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no c_resp, expected c_resp within 100 cycles", name);
        end else begin
            chk({name, "_presp"}, 256'(pmem_resp), 256'(exp_presp));
        end
        tick();
    endtask

    task automatic wait_quiet(input string name);
        int quiet = 0;
        for (int i = 0; i < 300 && quiet < 4; i++) begin
            tick();
            if (!pmem_read && !pmem_write && ewb_ready && exp_q.size() == 0) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) begin
            checks++;
            errors++;
            $display("FAIL %s_quiet: got %0d events pending, expected drained", name,
                     exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ewb_push = 1'b0; ewb_addr = '0; ewb_wdata = '0;
        c_read = 1'b0; c_address = '0; mem_stall = 1'b0;
        tick(); tick();
        chk("rst_ready", 256'(ewb_ready), 256'(1));
        chk("rst_pmem_write", 256'(pmem_write), 256'(0));
        chk("rst_pmem_read", 256'(pmem_read), 256'(0));
        chk("rst_c_resp", 256'(c_resp), 256'(0));
        chk("rst_pmem_address", 256'(pmem_address), 256'(0));
        chk("rst_pmem_wdata", pmem_wdata, 256'(0));
        chk("rst_c_rdata", c_rdata, 256'(0));
        rst_n = 1'b1;
        tick();

        // Single line drains the cycle after the push.
        expect_ev(EvWr, 32'h1000, {32{8'hAA}});
        push(32'h1000, {32{8'hAA}});
        chk("a_write_next_cycle", 256'(pmem_write), 256'(1));
        chk("a_addr", 256'(pmem_address), 256'(32'h1000));
        chk("a_wdata", pmem_wdata, {32{8'hAA}});
        wait_quiet("a");
        chk("a_ready_after", 256'(ewb_ready), 256'(1));

        // Fill to depth while memory stalls; 5th push ignored; FIFO drain order.
        mem_stall = 1'b1;
        expect_ev(EvWr, 32'h4000, 256'h1);
        expect_ev(EvWr, 32'h5000, 256'h2);
        expect_ev(EvWr, 32'h6000, 256'h3);
        expect_ev(EvWr, 32'h7000, 256'h4);
        push(32'h4000, 256'h1);
        push(32'h5000, 256'h2);
        push(32'h6000, 256'h3);
        chk("b_ready_3", 256'(ewb_ready), 256'(1));
        push(32'h7000, 256'h4);
        chk("b_ready_full", 256'(ewb_ready), 256'(0));
        push(32'h8000, 256'h5);
        chk("b_head_stable", 256'(pmem_address), 256'(32'h4000));
        mem_stall = 1'b0;
        wait_quiet("b");
        chk("b_ready_after", 256'(ewb_ready), 256'(1));

        // Same line pushed while its head copy is in flight: appended, in-flight data stable.
        mem_stall = 1'b1;
        expect_ev(EvWr, 32'h2400, 256'h11);
        expect_ev(EvWr, 32'h2400, 256'h22);
        push(32'h2400, 256'h11);
        push(32'h2400, 256'h22);
        chk("b2_wdata_stable", pmem_wdata, 256'h11);
        mem_stall = 1'b0;
        wait_quiet("b2");

        // Coalesce while memory is busy with a fill: one write, newest data, original addr.
        mem_stall = 1'b1;
        expect_ev(EvRd, 32'h9000, '0);
        expect_ev(EvResp, '0, pat(32'h9000));
        expect_ev(EvWr, 32'h2000, {32{8'h77}});
        c_address = 32'h9000;
        c_read = 1'b1;
        tick();
        push(32'h2000, {32{8'h55}});
        push(32'h2010, {32{8'h77}});
        mem_stall = 1'b0;
        wait_cresp("c_miss", 1'b1);
        c_read = 1'b0;
        wait_quiet("c");

        // Fill hitting a buffered line.
        mem_stall = 1'b1;
        c_address = 32'h9100;
        c_read = 1'b1;
        tick();
        push(32'h3000, {32{8'h3C}});
        expect_ev(EvRd, 32'h9100, '0);
        expect_ev(EvResp, '0, pat(32'h9100));
`ifdef EWB_FWD_EN
        expect_ev(EvResp, '0, {32{8'h3C}});
        expect_ev(EvWr, 32'h3000, {32{8'h3C}});
`else
        expect_ev(EvWr, 32'h3000, {32{8'h3C}});
        expect_ev(EvRd, 32'h3000, '0);
        expect_ev(EvResp, '0, {32{8'h3C}});
`endif
        mem_stall = 1'b0;
        wait_cresp("d_first", 1'b1);
        c_address = 32'h3000;
`ifdef EWB_FWD_EN
        tick();
        chk("d_fwd_resp", 256'(c_resp), 256'(1));
        chk("d_fwd_data", c_rdata, {32{8'h3C}});
        chk("d_fwd_no_read", 256'(pmem_read), 256'(0));
        tick();
`else
        wait_cresp("d_hit", 1'b1);
`endif
        c_read = 1'b0;
        wait_quiet("d");

        // Miss fill with a non-empty buffer: read goes before the pending write.
        mem_stall = 1'b1;
        expect_ev(EvRd, 32'h9200, '0);
        expect_ev(EvResp, '0, pat(32'h9200));
        expect_ev(EvRd, 32'hB000, '0);
        expect_ev(EvResp, '0, pat(32'hB000));
        expect_ev(EvWr, 32'hA000, {32{8'hE1}});
        c_address = 32'h9200;
        c_read = 1'b1;
        tick();
        push(32'hA000, {32{8'hE1}});
        mem_stall = 1'b0;
        wait_cresp("e_first", 1'b1);
        c_address = 32'hB000;
        wait_cresp("e_miss", 1'b1);
        c_read = 1'b0;
        wait_quiet("e");

        // Reset during a stalled drain with 3 queued lines drops everything.
        mem_stall = 1'b1;
        push(32'hC000, 256'hC);
        push(32'hD000, 256'hD);
        push(32'hE000, 256'hE);
        chk("f_writing", 256'(pmem_write), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("f_write_drop", 256'(pmem_write), 256'(0));
        chk("f_addr_drop", 256'(pmem_address), 256'(0));
        tick();
        rst_n = 1'b1;
        mem_stall = 1'b0;
        repeat (10) tick();
        chk("f_ready", 256'(ewb_ready), 256'(1));
        chk("f_no_write", 256'(pmem_write), 256'(0));
        chk("f_no_read", 256'(pmem_read), 256'(0));

        // Count restarted from zero: ready drops only after the 4th push.
        mem_stall = 1'b1;
        push(32'h1100, 256'h1);
        push(32'h1200, 256'h2);
        push(32'h1300, 256'h3);
        chk("f_cnt_ready3", 256'(ewb_ready), 256'(1));
        push(32'h1400, 256'h4);
        chk("f_cnt_full", 256'(ewb_ready), 256'(0));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_stall = 1'b0;
        repeat (5) tick();

        chk("sb_empty", 256'(exp_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
